// File: rtl/amba_axi4_stream_pkt_source_pkg.sv
// Shared AXI4-Stream types for the packet source.
// Optional feature macro: AXI4_STREAM_SRC_PARTIAL_LAST_EN (partial TKEEP/TSTRB on the last beat).
// Types are sized for the widest supported configuration; each module keeps
// only the low slice that its own parameters call for.
package amba_axi4_stream_pkt_source_pkg;

  localparam int AXIS_MAX_BYTES  = 64;
  localparam int AXIS_MAX_ID_W   = 32;
  localparam int AXIS_MAX_DEST_W = 32;
  localparam int AXIS_MAX_USER_W = 32;
  localparam int AXIS_MAX_LEN_W  = 32;

  typedef logic [8*AXIS_MAX_BYTES-1:0] axi_data_t;
  typedef logic [AXIS_MAX_BYTES-1:0]   axi_strb_t;
  typedef logic [AXIS_MAX_BYTES-1:0]   axi_keep_t;
  typedef logic [AXIS_MAX_ID_W-1:0]    axi_id_t;
  typedef logic [AXIS_MAX_DEST_W-1:0]  axi_dest_t;
  typedef logic [AXIS_MAX_USER_W-1:0]  axi_user_t;
  typedef logic [AXIS_MAX_LEN_W-1:0]   axi_len_t;

  typedef enum logic [0:0] {
    SRC_IDLE = 1'b0,
    SRC_SEND = 1'b1
  } src_state_t;

  // Mask with the low nbytes bits set.
  function automatic axi_keep_t keep_mask(input int nbytes);
    axi_keep_t m;
    m = '0;
    for (int i = 0; i < AXIS_MAX_BYTES; i++) begin
      if (i < nbytes) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Width of the "last-beat bytes minus one" field.
  function automatic int last_bytes_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/amba_axi4_stream_pkt_source_if.sv
// Command + AXI4-Stream bundle for the packet source.
// Optional feature macro: AXI4_STREAM_SRC_PARTIAL_LAST_EN adds cmd_last_bytes.
// master = the source side (drives cmd_ready, T* and pkt_done).
interface amba_axi4_stream_pkt_source_if
  import amba_axi4_stream_pkt_source_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int DEST_WIDTH       = 4,
  parameter int ID_WIDTH         = 8,
  parameter int USER_WIDTH       = 1,
  parameter int LEN_WIDTH        = 8
);
  localparam int DATA_W = 8 * DATA_WIDTH_BYTES;

  // Command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_W-1:0]     cmd_seed;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [DEST_WIDTH-1:0] cmd_dest;
  logic [USER_WIDTH-1:0] cmd_user;

  // Stream channel
  logic                        TVALID;
  logic                        TREADY;
  logic [DATA_W-1:0]           TDATA;
  logic [DATA_WIDTH_BYTES-1:0] TSTRB;
  logic [DATA_WIDTH_BYTES-1:0] TKEEP;
  logic                        TLAST;
  logic [ID_WIDTH-1:0]         TID;
  logic [DEST_WIDTH-1:0]       TDEST;
  logic [USER_WIDTH-1:0]       TUSER;

  logic                        pkt_done;

`ifdef AXI4_STREAM_SRC_PARTIAL_LAST_EN
  localparam int LB_W = last_bytes_width(DATA_WIDTH_BYTES);
  logic [LB_W-1:0] cmd_last_bytes;

  modport master (
    input  cmd_valid, cmd_len, cmd_seed, cmd_id, cmd_dest, cmd_user, cmd_last_bytes, TREADY,
    output cmd_ready, TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER, pkt_done
  );
  modport slave (
    output cmd_valid, cmd_len, cmd_seed, cmd_id, cmd_dest, cmd_user, cmd_last_bytes, TREADY,
    input  cmd_ready, TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER, pkt_done
  );
`else
  modport master (
    input  cmd_valid, cmd_len, cmd_seed, cmd_id, cmd_dest, cmd_user, TREADY,
    output cmd_ready, TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER, pkt_done
  );
  modport slave (
    output cmd_valid, cmd_len, cmd_seed, cmd_id, cmd_dest, cmd_user, TREADY,
    input  cmd_ready, TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER, pkt_done
  );
`endif

endinterface

// File: rtl/amba_axi4_stream_pkt_source.sv
// AXI4-Stream packet source: one command beat -> (len+1) stream beats with
// TDATA = seed + beat index, TLAST on the final beat, pkt_done pulse after it.
// All stream outputs come straight from flops, so nothing on the T* side
// depends combinationally on TREADY.
// Optional feature macro: AXI4_STREAM_SRC_PARTIAL_LAST_EN (partial TKEEP/TSTRB
// and zeroed upper bytes on the last beat, from cmd_last_bytes).
module amba_axi4_stream_pkt_source
  import amba_axi4_stream_pkt_source_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int DEST_WIDTH       = 4,
  parameter int ID_WIDTH         = 8,
  parameter int USER_WIDTH       = 1,
  parameter int LEN_WIDTH        = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  amba_axi4_stream_pkt_source_if.master  bus
);

  localparam int DATA_W = 8 * DATA_WIDTH_BYTES;

  src_state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [LEN_WIDTH-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]           seed_q, seed_d;
  logic [DATA_W-1:0]           tdata_q, tdata_d;
  logic [DATA_W-1:0]           data_raw;
  logic [ID_WIDTH-1:0]         id_q, id_d;
  logic [DEST_WIDTH-1:0]       dest_q, dest_d;
  logic [USER_WIDTH-1:0]       user_q, user_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic                        pkt_done_q, pkt_done_d;
  logic [DATA_WIDTH_BYTES-1:0] tkeep_q, tkeep_d;

`ifdef AXI4_STREAM_SRC_PARTIAL_LAST_EN
  localparam int LB_W = last_bytes_width(DATA_WIDTH_BYTES);
  logic [LB_W-1:0] last_bytes_q, last_bytes_d;
  axi_keep_t       last_mask_full;
`endif

  // Commands are only taken when idle and out of reset.
  assign bus.cmd_ready = (state_q == SRC_IDLE) & ~ARESET;

  assign bus.TVALID   = tvalid_q;
  assign bus.TDATA    = tdata_q;
  assign bus.TSTRB    = tkeep_q;
  assign bus.TKEEP    = tkeep_q;
  assign bus.TLAST    = tlast_q;
  assign bus.TID      = id_q;
  assign bus.TDEST    = dest_q;
  assign bus.TUSER    = user_q;
  assign bus.pkt_done = pkt_done_q;

  // Next-state: command capture in idle, beat advance on each accepted beat.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    seed_d     = seed_q;
    id_d       = id_q;
    dest_d     = dest_q;
    user_d     = user_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    pkt_done_d = 1'b0;
    data_raw   = tdata_q;
`ifdef AXI4_STREAM_SRC_PARTIAL_LAST_EN
    last_bytes_d = last_bytes_q;
`endif
    case (state_q)
      SRC_IDLE: begin
        // cmd_ready is implied here; reset overrides in the register block.
        if (bus.cmd_valid) begin
          state_d    = SRC_SEND;
          len_d      = bus.cmd_len;
          seed_d     = bus.cmd_seed;
          id_d       = bus.cmd_id;
          dest_d     = bus.cmd_dest;
          user_d     = bus.cmd_user;
          beat_cnt_d = '0;
          tvalid_d   = 1'b1;
          tlast_d    = (bus.cmd_len == '0);
          data_raw   = bus.cmd_seed;
`ifdef AXI4_STREAM_SRC_PARTIAL_LAST_EN
          last_bytes_d = bus.cmd_last_bytes;
`endif
        end
      end
      SRC_SEND: begin
        if (bus.TREADY) begin
          if (tlast_q) begin
            state_d    = SRC_IDLE;
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            pkt_done_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
            tlast_d    = (beat_cnt_d == len_q);
            // Wrap past the top of TDATA is intentional and silent.
            data_raw   = seed_q + DATA_W'(beat_cnt_d);
          end
        end
      end
      default: state_d = SRC_IDLE;
    endcase
  end

`ifdef AXI4_STREAM_SRC_PARTIAL_LAST_EN
  // Byte qualifiers: partial only on the last beat of a multi-byte bus.
  always_comb begin
    last_mask_full = keep_mask(int'(last_bytes_d) + 1);
    tkeep_d        = '1;
    if (tlast_d && (DATA_WIDTH_BYTES > 1)) begin
      tkeep_d = last_mask_full[DATA_WIDTH_BYTES-1:0];
    end
  end

  // Bytes outside the kept range are driven to zero.
  for (genvar gi = 0; gi < DATA_WIDTH_BYTES; gi++) begin : g_byte
    assign tdata_d[8*gi +: 8] = tkeep_d[gi] ? data_raw[8*gi +: 8] : 8'h00;
  end
`else
  // Byte qualifiers are always full width.
  always_comb begin
    tkeep_d = '1;
  end

  assign tdata_d = data_raw;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= SRC_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      seed_q     <= '0;
      tdata_q    <= '0;
      id_q       <= '0;
      dest_q     <= '0;
      user_q     <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      pkt_done_q <= 1'b0;
      tkeep_q    <= '1;
`ifdef AXI4_STREAM_SRC_PARTIAL_LAST_EN
      last_bytes_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      seed_q     <= seed_d;
      tdata_q    <= tdata_d;
      id_q       <= id_d;
      dest_q     <= dest_d;
      user_q     <= user_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      pkt_done_q <= pkt_done_d;
      tkeep_q    <= tkeep_d;
`ifdef AXI4_STREAM_SRC_PARTIAL_LAST_EN
      last_bytes_q <= last_bytes_d;
`endif
    end
  end

endmodule

// File: tb/tb_amba_axi4_stream_pkt_source.sv
// Bench for amba_axi4_stream_pkt_source (default build, 1-byte TDATA).
// A packet-level model turns every accepted command into a queue of expected
// beats; a compare process checks the DUT outputs every cycle against it.
module tb_amba_axi4_stream_pkt_source;

  logic aclk;
  logic areset;

  amba_axi4_stream_pkt_source_if bus ();

  amba_axi4_stream_pkt_source dut (
    .ACLK   (aclk),
    .ARESET (areset),
    .bus    (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // TREADY source: 0 = always high, 1 = random, 2 = follow rdy_manual
  int   rdy_mode   = 2;
  logic rdy_manual = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] id;
    logic [3:0] dest;
    logic       user;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] log_data[$];
  logic       log_last[$];
  logic [7:0] log_id[$];
  logic [3:0] log_dest[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // TREADY driver, a little after the falling edge
  initial begin
    bus.TREADY = 1'b0;
    forever begin
      @(negedge aclk);
      #1;
      if (rdy_mode == 0)      bus.TREADY = 1'b1;
      else if (rdy_mode == 1) bus.TREADY = 1'($urandom_range(0, 1));
      else                    bus.TREADY = rdy_manual;
    end
  end

  // Model + compare, sampled just before each rising edge
  initial begin
    bit    armed     = 1'b0;
    bit    exp_done  = 1'b0;
    bit    after_rst = 1'b0;
    beat_t b;
    forever begin
      @(negedge aclk);
      #4;
      if (armed) begin
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(!areset && exp_q.size() == 0));
        chk("pkt_done",  64'(bus.pkt_done),  64'(exp_done));
        chk("TVALID",    64'(bus.TVALID),    64'(exp_q.size() > 0));
        chk("TKEEP",     64'(bus.TKEEP),     64'(1));
        chk("TSTRB",     64'(bus.TSTRB),     64'(1));
        if (after_rst) begin
          chk("rst_TDATA", 64'(bus.TDATA), 64'(0));
          chk("rst_TLAST", 64'(bus.TLAST), 64'(0));
          chk("rst_TID",   64'(bus.TID),   64'(0));
          chk("rst_TDEST", 64'(bus.TDEST), 64'(0));
          chk("rst_TUSER", 64'(bus.TUSER), 64'(0));
        end
        if (exp_q.size() > 0) begin
          chk("TDATA", 64'(bus.TDATA), 64'(exp_q[0].data));
          chk("TLAST", 64'(bus.TLAST), 64'(exp_q[0].last));
          chk("TID",   64'(bus.TID),   64'(exp_q[0].id));
          chk("TDEST", 64'(bus.TDEST), 64'(exp_q[0].dest));
          chk("TUSER", 64'(bus.TUSER), 64'(exp_q[0].user));
        end
      end
      // What the coming rising edge does
      exp_done  = 1'b0;
      after_rst = 1'b0;
      if (areset) begin
        exp_q.delete();
        after_rst = 1'b1;
        armed     = 1'b1;
      end else if (armed) begin
        if (bus.pkt_done) done_cnt++;
        if (bus.TVALID && bus.TREADY) begin
          log_data.push_back(bus.TDATA);
          log_last.push_back(bus.TLAST);
          log_id.push_back(bus.TID);
          log_dest.push_back(bus.TDEST);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            exp_done = b.last;
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          for (int i = 0; i <= int'(bus.cmd_len); i++) begin
            b.data = bus.cmd_seed + 8'(i);
            b.last = (i == int'(bus.cmd_len));
            b.id   = bus.cmd_id;
            b.dest = bus.cmd_dest;
            b.user = bus.cmd_user;
            exp_q.push_back(b);
          end
        end
      end
    end
  end

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
    log_id.delete();
    log_dest.delete();
  endtask

  // Present a command, hold it until accepted, then scramble the fields.
  task automatic send_cmd(input logic [7:0] len, input logic [7:0] seed,
                          input logic [7:0] id, input logic [3:0] dest, input logic user);
    bit ok = 1'b0;
    @(negedge aclk);
    bus.cmd_len   = len;
    bus.cmd_seed  = seed;
    bus.cmd_id    = id;
    bus.cmd_dest  = dest;
    bus.cmd_user  = user;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (bus.cmd_ready) begin
        ok = 1'b1;
        @(posedge aclk);
        #1;
      end else begin
        @(negedge aclk);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = ~len;
    bus.cmd_seed  = ~seed;
    bus.cmd_id    = ~id;
    bus.cmd_dest  = ~dest;
    bus.cmd_user  = ~user;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_cmd: cmd_ready never seen, got 0, expected 1");
    end
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (done_cnt > start) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_done: got no pkt_done within %0d cycles, expected one", budget);
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [7:0] d, input logic l);
    if (idx < log_data.size()) begin
      chk({nm, "_data"}, 64'(log_data[idx]), 64'(d));
      chk({nm, "_last"}, 64'(log_last[idx]), 64'(l));
    end else begin
      chk({nm, "_present"}, 64'(log_data.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int start;
    int n_last;
    areset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_seed  = '0;
    bus.cmd_id    = '0;
    bus.cmd_dest  = '0;
    bus.cmd_user  = '0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    // 4 beats from 0x10, no backpressure
    rdy_mode = 0;
    clear_log();
    send_cmd(8'd3, 8'h10, 8'h01, 4'h1, 1'b0);
    wait_done(50);
    chk("t1_beats", 64'(log_data.size()), 64'(4));
    chk_log("t1_b0", 0, 8'h10, 1'b0);
    chk_log("t1_b1", 1, 8'h11, 1'b0);
    chk_log("t1_b2", 2, 8'h12, 1'b0);
    chk_log("t1_b3", 3, 8'h13, 1'b1);
    repeat (2) @(negedge aclk);

    // single-beat packet
    clear_log();
    send_cmd(8'd0, 8'hAA, 8'h05, 4'h3, 1'b1);
    wait_done(50);
    chk("t2_beats", 64'(log_data.size()), 64'(1));
    chk_log("t2_b0", 0, 8'hAA, 1'b1);
    if (log_id.size() > 0) begin
      chk("t2_tid",   64'(log_id[0]),   64'(8'h05));
      chk("t2_tdest", 64'(log_dest[0]), 64'(4'h3));
    end
    repeat (2) @(negedge aclk);

    // TREADY low for 4 cycles while beat 1 is presented
    rdy_mode   = 2;
    rdy_manual = 1'b1;
    clear_log();
    send_cmd(8'd2, 8'h40, 8'h22, 4'h7, 1'b0);
    @(negedge aclk);
    @(negedge aclk);
    rdy_manual = 1'b0;
    repeat (3) @(negedge aclk);
    @(negedge aclk);
    rdy_manual = 1'b1;
    wait_done(50);
    chk("t3_beats", 64'(log_data.size()), 64'(3));
    chk_log("t3_b0", 0, 8'h40, 1'b0);
    chk_log("t3_b1", 1, 8'h41, 1'b0);
    chk_log("t3_b2", 2, 8'h42, 1'b1);
    repeat (2) @(negedge aclk);

    // data wrap
    rdy_mode = 0;
    clear_log();
    send_cmd(8'd3, 8'hFE, 8'h33, 4'h9, 1'b1);
    wait_done(50);
    chk_log("t4_b0", 0, 8'hFE, 1'b0);
    chk_log("t4_b1", 1, 8'hFF, 1'b0);
    chk_log("t4_b2", 2, 8'h00, 1'b0);
    chk_log("t4_b3", 3, 8'h01, 1'b1);
    repeat (2) @(negedge aclk);

    // reset during beat 2 of 6, with a command pending through the reset
    rdy_mode   = 2;
    rdy_manual = 1'b1;
    clear_log();
    start = done_cnt;
    send_cmd(8'd5, 8'h20, 8'h44, 4'h2, 1'b0);
    @(negedge aclk);
    @(negedge aclk);
    @(negedge aclk);
    areset        = 1'b1;
    bus.cmd_len   = 8'd0;
    bus.cmd_seed  = 8'h99;
    bus.cmd_valid = 1'b1;
    @(negedge aclk);
    areset        = 1'b0;
    bus.cmd_valid = 1'b0;
    #4;
    chk("t5_tvalid_after_rst", 64'(bus.TVALID), 64'(0));
    repeat (5) @(negedge aclk);
    chk("t5_no_pkt_done", 64'(done_cnt), 64'(start));
    chk("t5_beats", 64'(log_data.size()), 64'(2));
    chk_log("t5_b0", 0, 8'h20, 1'b0);
    chk_log("t5_b1", 1, 8'h21, 1'b0);
    clear_log();
    send_cmd(8'd1, 8'h70, 8'h45, 4'h4, 1'b1);
    wait_done(50);
    chk("t5_next_beats", 64'(log_data.size()), 64'(2));
    chk_log("t5_n0", 0, 8'h70, 1'b0);
    chk_log("t5_n1", 1, 8'h71, 1'b1);
    repeat (2) @(negedge aclk);

    // maximum length: 256 beats
    rdy_mode = 0;
    clear_log();
    send_cmd(8'd255, 8'h00, 8'h66, 4'hC, 1'b0);
    wait_done(400);
    chk("t6_beats", 64'(log_data.size()), 64'(256));
    n_last = 0;
    foreach (log_last[i]) if (log_last[i]) n_last++;
    chk("t6_tlast_count", 64'(n_last), 64'(1));
    chk_log("t6_b128", 128, 8'h80, 1'b0);
    chk_log("t6_b255", 255, 8'hFF, 1'b1);
    repeat (2) @(negedge aclk);

    // random backpressure, model-checked only
    rdy_mode = 1;
    for (int p = 0; p < 4; p++) begin
      send_cmd(8'($urandom_range(0, 9)), 8'($urandom), 8'($urandom),
               4'($urandom), 1'($urandom_range(0, 1)));
      wait_done(300);
    end
    rdy_mode = 0;
    repeat (3) @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
